// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix scan driver with binary-coded-modulation colour depth.
// Shifts one row pair per bit plane, latches it, then lights it for BASE_ON << plane cycles.
module hub75_bcm_driver #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 4,
  parameter int DEPTH    = 4,
  parameter int BASE_ON  = 8,
  localparam int COL_W   = $clog2(COLS),
  localparam int PL_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  pix_req,
  output logic [COL_W-1:0]      pix_col,
  output logic [ROW_BITS-1:0]   pix_row,
  output logic [PL_W-1:0]       pix_plane,
  input  logic [3*DEPTH-1:0]    rgb0_in,
  input  logic [3*DEPTH-1:0]    rgb1_in,
  output logic                  R0,
  output logic                  G0,
  output logic                  B0,
  output logic                  R1,
  output logic                  G1,
  output logic                  B1,
  output logic                  SCLK,
  output logic                  LAT,
  output logic                  OE,
  output logic [ROW_BITS-1:0]   addr,
  output logic                  frame_done
);

  localparam int CW = COL_W + 2;
  localparam int DW = $clog2(BASE_ON << (DEPTH - 1)) + 1;
  localparam logic [CW-1:0]  LAST_CYC = CW'(2 * COLS + 1);
  localparam logic [COL_W:0] NCOLS    = (COL_W + 1)'(COLS);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cyc, cyc_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic [DW-1:0]   on_len;
  logic [COL_W:0]  slot, slot_n;
  logic            plane_done;
  logic            req_n, sclk_n, lat_n, oe_n;
  logic [COL_W-1:0] col_n;

  logic [DEPTH-1:0] r0f, g0f, b0f, r1f, g1f, b1f;

  assign r0f = rgb0_in[3*DEPTH-1 -: DEPTH];
  assign g0f = rgb0_in[2*DEPTH-1 -: DEPTH];
  assign b0f = rgb0_in[DEPTH-1:0];
  assign r1f = rgb1_in[3*DEPTH-1 -: DEPTH];
  assign g1f = rgb1_in[2*DEPTH-1 -: DEPTH];
  assign b1f = rgb1_in[DEPTH-1:0];

  // Each shift slot is two cycles: phase 0 requests a pixel, phase 1 may pulse SCLK.
  assign slot   = cyc[CW-1:1];
  assign slot_n = cyc_n[CW-1:1];
  assign on_len = DW'(BASE_ON) << pix_plane;

  always_comb begin
    state_n    = state;
    cyc_n      = cyc;
    dcnt_n     = dcnt;
    plane_done = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_n = SHIFT;
      end
      SHIFT: begin
        if (cyc == LAST_CYC) begin
          state_n = LATCH;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      LATCH: begin
        state_n = DISPLAY;
        dcnt_n  = '0;
      end
      DISPLAY: begin
        if (dcnt == on_len - DW'(1)) begin
          plane_done = 1'b1;
          state_n    = en ? SHIFT : IDLE;
          dcnt_n     = '0;
          cyc_n      = '0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Panel strobes are decoded from the next state so they register in step with it.
    req_n  = (state_n == SHIFT) && !cyc_n[0] && (slot_n < NCOLS);
    sclk_n = (state_n == SHIFT) && cyc_n[0] && (slot_n != '0);
    lat_n  = (state_n == LATCH);
    oe_n   = (state_n != DISPLAY);
    col_n  = req_n ? slot_n[COL_W-1:0] : pix_col;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cyc        <= '0;
      dcnt       <= '0;
      pix_row    <= '0;
      pix_plane  <= '0;
      addr       <= '0;
      {R0, G0, B0, R1, G1, B1} <= '0;
      SCLK       <= 1'b0;
      LAT        <= 1'b0;
      OE         <= 1'b1;
      pix_req    <= 1'b0;
      pix_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cyc        <= cyc_n;
      dcnt       <= dcnt_n;
      SCLK       <= sclk_n;
      LAT        <= lat_n;
      OE         <= oe_n;
      pix_req    <= req_n;
      pix_col    <= col_n;
      frame_done <= 1'b0;

      if (state_n == LATCH) addr <= pix_row;

      // RAM data answering the phase-0 request is valid during phase 1.
      if (state == SHIFT && cyc[0] && slot < NCOLS) begin
        R0 <= r0f[pix_plane];
        G0 <= g0f[pix_plane];
        B0 <= b0f[pix_plane];
        R1 <= r1f[pix_plane];
        G1 <= g1f[pix_plane];
        B1 <= b1f[pix_plane];
      end

      if (plane_done) begin
        if (pix_plane == PL_W'(DEPTH - 1)) begin
          pix_plane  <= '0;
          pix_row    <= pix_row + ROW_BITS'(1);
          frame_done <= &pix_row;
        end else begin
          pix_plane <= pix_plane + PL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver: shift table, mid-shift reset, BCM weights,
// frame wrap and stop/resume, with a one-cycle-latency frame-buffer model.
module tb_hub75_bcm_driver;
  localparam int COLS = 4, ROW_BITS = 2, DEPTH = 2, BASE_ON = 2;

  logic       clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic       pix_req;
  logic [1:0] pix_col, pix_row, addr;
  logic       pix_plane;
  logic [5:0] rgb0_in = '0, rgb1_in = '0;
  logic       R0, G0, B0, R1, G1, B1, SCLK, LAT, OE, frame_done;

  int checks = 0, failures = 0;
  int ram_mode = 0;

  typedef struct packed {
    logic       en;
    logic [4:0] exp_flags;   // {pix_req, SCLK, LAT, OE, R0}
    logic [1:0] exp_col;
  } vec_t;
  vec_t tbl [13];

  hub75_bcm_driver #(.COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .BASE_ON(BASE_ON)) dut (
    .clk(clk), .rst(rst), .en(en),
    .pix_req(pix_req), .pix_col(pix_col), .pix_row(pix_row), .pix_plane(pix_plane),
    .rgb0_in(rgb0_in), .rgb1_in(rgb1_in),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .SCLK(SCLK), .LAT(LAT), .OE(OE), .addr(addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: data appears the cycle after the request.
  always @(posedge clk) begin
    if (pix_req) begin
      if (ram_mode == 0) begin
        rgb0_in <= {pix_col[0], pix_col[0], 4'b0000};
        rgb1_in <= 6'b000000;
      end else begin
        rgb0_in <= 6'b10_01_11;
        rgb1_in <= 6'b01_10_00;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en_v);
    en = en_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_oe"}, OE, 1);
    checkOutput({tag, "_ctrl"}, {SCLK, LAT, pix_req, frame_done}, 0);
    checkOutput({tag, "_rgb"}, {R0, G0, B0, R1, G1, B1}, 0);
    checkOutput({tag, "_addr"}, addr, 0);
    checkOutput({tag, "_pos"}, {pix_row, pix_plane, pix_col}, 0);
  endtask

  // Runs until the next display window ends; checks LAT count, on-time, colours, overlap.
  task automatic runPlane(input string tag, input int exp_on, input logic [5:0] exp_rgb);
    int lat_cnt = 0, on_cnt = 0, overlap = 0, n = 0;
    logic seen = 1'b0;
    logic [5:0] rgb_seen = '0;
    while (n < 400) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (LAT) lat_cnt++;
      if ((!OE && (LAT || SCLK)) || (LAT && SCLK)) overlap++;
      if (!OE) begin
        if (!seen) rgb_seen = {R0, G0, B0, R1, G1, B1};
        seen = 1'b1;
        on_cnt++;
      end else if (seen) begin
        break;
      end
    end
    checkOutput({tag, "_done"}, int'(seen && OE), 1);
    checkOutput({tag, "_lat"}, lat_cnt, 1);
    checkOutput({tag, "_on"}, on_cnt, exp_on);
    checkOutput({tag, "_rgb"}, rgb_seen, exp_rgb);
    checkOutput({tag, "_overlap"}, overlap, 0);
  endtask

  initial begin
    int k, nfd;
    logic [1:0] prev_row;

    tbl = '{
      '{1'b1, 5'b10010, 2'd0}, '{1'b1, 5'b00010, 2'd0},
      '{1'b1, 5'b10010, 2'd1}, '{1'b1, 5'b01010, 2'd0},
      '{1'b1, 5'b10011, 2'd2}, '{1'b1, 5'b01011, 2'd0},
      '{1'b1, 5'b10010, 2'd3}, '{1'b1, 5'b01010, 2'd0},
      '{1'b1, 5'b00011, 2'd0}, '{1'b1, 5'b01011, 2'd0},
      '{1'b1, 5'b00111, 2'd0}, '{1'b1, 5'b00001, 2'd0},
      '{1'b1, 5'b00001, 2'd0}
    };

    rst = 1'b0;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("por");

    // Plane 0, row 0 with column-parity red data.
    rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].en);
      checkOutput($sformatf("shift_t%0d", i), {pix_req, SCLK, LAT, OE, R0}, tbl[i].exp_flags);
      if (tbl[i].exp_flags[4])
        checkOutput($sformatf("col_t%0d", i), pix_col, tbl[i].exp_col);
    end

    // Into plane 1 slot 2 phase 1, then reset in the middle of the shift.
    repeat (6) applyStimulus(1'b1);
    checkOutput("mid_sclk", SCLK, 1);
    checkOutput("mid_plane", pix_plane, 1);
    checkOutput("mid_r0", R0, 1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("mid");
    rst = 1'b1;
    ram_mode = 1;
    applyStimulus(1'b1);
    checkOutput("resume_req", {pix_req, pix_col, pix_plane}, 4'b1000);

    runPlane("bcm_p0", 2, 6'b011_100);
    runPlane("bcm_p1", 4, 6'b101_010);

    // Two free-running frames from a clean start.
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    k = 0;
    nfd = 0;
    prev_row = 2'd0;
    for (int t = 0; t < 240; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (LAT) begin
        checkOutput($sformatf("addr_k%0d", k), addr, (k / 2) % 4);
        k++;
      end
      if (frame_done) begin
        checkOutput($sformatf("fd_time%0d", nfd), t, 112 * (nfd + 1));
        checkOutput($sformatf("fd_row%0d", nfd), {prev_row, pix_row, pix_plane}, 5'b11_00_0);
        nfd++;
      end
      prev_row = pix_row;
    end
    checkOutput("frame_count", nfd, 2);
    checkOutput("lat_count", k, 17);

    // Drop en in slot 1 of row 1 plane 0; the plane must finish, then idle.
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (31) applyStimulus(1'b1);
    checkOutput("stop_pos", {pix_req, pix_col, pix_row, pix_plane}, 6'b1_01_01_0);
    en = 1'b0;
    runPlane("stop_p", 2, 6'b011_100);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("idle_%0d", i), {OE, pix_req, SCLK, LAT}, 4'b1000);
    end
    checkOutput("stop_hold", {pix_row, pix_plane}, 3'b01_1);
    applyStimulus(1'b1);
    checkOutput("restart", {pix_req, pix_col, pix_row, pix_plane}, 6'b1_00_01_1);
    runPlane("restart_p1", 4, 6'b101_010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hub75_bcm_driver.md
# hub75_bcm_driver

Parametrised HUB75 LED-matrix scan driver with binary-coded-modulation (BCM) colour depth. It is the next generation of the single-bit matrix driver. It adds:
- a generic column count, row-address width and bit-plane depth;
- a real shift clock output;
- a pixel-fetch handshake towards the frame buffer;
- weighted OE on-time per bit plane, run/stop control and a frame-done strobe.

It sits between the frame-buffer RAM, which has one-cycle read latency, and the panel connector pins.

## Interface
Parameters:
- COLS, 64, pixels per shifted row (≥2); COL_W = clog2(COLS)
- ROW_BITS, 4, row-address width (panel scans 2^ROW_BITS row pairs)
- DEPTH, 4, bit planes per colour (1..8); PL_W = max(1, clog2(DEPTH))
- BASE_ON, 8, OE-low cycles for bit plane 0 (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  run enable
- pix_req  out  1  frame-buffer read strobe
- pix_col  out  COL_W  column being requested
- pix_row  out  ROW_BITS  row pair being requested
- pix_plane  out  PL_W  current bit plane
- rgb0_in  in  3*DEPTH  upper-half pixel {R[DEPTH-1:0],G[..],B[..]}, valid the cycle after pix_req
- rgb1_in  in  3*DEPTH  lower-half pixel, same layout and timing
- R0,G0,B0,R1,G1,B1  out  1 each  panel colour data (bit pix_plane of each field)
- SCLK  out  1  panel shift clock
- LAT  out  1  panel latch
- OE  out  1  panel blank; 1 = blanked (panel OE is active-low)
- addr  out  ROW_BITS  panel row address {.., D, C, B, A}
- frame_done  out  1  one-cycle strobe at the end of the last plane of the last row

## Operation
- FSM states: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: OE=1, no pix_req. The FSM goes to SHIFT on the cycle after en=1 is sampled.
- SHIFT runs 2*COLS+2 cycles, organised as slots s=0..COLS of 2 cycles each (phase 0, phase 1).
  - Slot s<COLS, phase 0: pix_req=1, pix_col=s.
  - End of phase 1 of slot s: the driver registers bit pix_plane of each colour field of rgb*_in onto R0..B1.
  - SCLK=1 in phase 1 of slots 1..COLS only. This gives exactly COLS rising edges, each with data stable for 1 cycle before it.
  - OE=1 throughout SHIFT.
- LATCH (1 cycle): LAT=1, OE=1. addr is updated to pix_row in this cycle.
- DISPLAY: OE=0 for BASE_ON << pix_plane cycles, LAT=0. On exit the plane/row counters advance:
  - If pix_plane < DEPTH-1: pix_plane+1, same row.
  - Otherwise: pix_plane=0 and pix_row+1. pix_row wraps from 2^ROW_BITS-1 to 0, and frame_done=1 for that exit cycle.
- Exit from DISPLAY goes to SHIFT if en=1, otherwise to IDLE.
- en=0 mid-SHIFT/LATCH: the current plane is completed through DISPLAY, then the FSM enters IDLE. pix_row and pix_plane keep their advanced values, so re-enabling resumes at the next plane.
- Bit plane 0 is the LSB and the shortest display time.
- The display counter is wide enough for BASE_ON<<(DEPTH-1) with no overflow.
- R0..B1 hold their last value outside SHIFT.

## Timing
- Reset (rst=0 at a rising edge), outputs from the next cycle:
  - state=IDLE, pix_row=0, pix_plane=0, addr=0;
  - R0..B1=0, SCLK=0, LAT=0, OE=1, pix_req=0, pix_col=0, frame_done=0.
- Reset overrides every state, including mid-SHIFT and mid-DISPLAY. No partial LAT or SCLK pulse may follow.
- Read latency assumed: exactly 1 cycle, from pix_req to valid rgb*_in.
- SCLK, LAT and OE are registered outputs, glitch-free. LAT and SCLK are never high in the same cycle.
- OE=0 never overlaps LAT=1 or SCLK activity.
- Cycles per row-plane p: (2*COLS+2) + 1 + (BASE_ON<<p).
- Frame period = 2^ROW_BITS × sum over p of that value, plus 1 IDLE cycle only at start.

## Test plan
Bench parameters: COLS=4, ROW_BITS=2, DEPTH=2, BASE_ON=2.
- **Reset:** rst=0 for 3 cycles during slot 2 of SHIFT, then rst=1 → next cycle OE=1, SCLK=0, LAT=0, addr=0, R0..B1=0. The following SHIFT starts with pix_col=0, pix_plane=0.
- **Shift:** en=1 after reset, RAM model returns rgb0_in R bits = column parity → per SHIFT:
  - 10 cycles, 4 SCLK rising edges, pix_col sequence 0,1,2,3;
  - R0 sampled at each SCLK rise = 0,1,0,1.
- **BCM:** rgb0_in = {R=2'b10, G=2'b01, B=2'b11} →
  - plane 0: OE low 2 cycles, R0=0, G0=1, B0=1;
  - plane 1: OE low 4 cycles, R0=1, G0=0, B0=1;
  - exactly one LAT pulse before each.
- **Row wrap / frame:** free-run 2 frames →
  - addr sequence 0,0,1,1,2,2,3,3,0…, one value per plane;
  - frame_done pulses exactly every 112 cycles, coincident with pix_row 3→0.
- **Stop/resume:** en=0 in SHIFT slot 1 of row 1 plane 0 →
  - that plane completes (LAT, 2 OE-low cycles), then IDLE with OE=1 and no pix_req;
  - after en=1, SHIFT resumes at pix_row=1, pix_plane=1.
